// File: rtl/pulse_rx.sv
// pulse_rx: threshold pulse detector with peak/timestamp capture and a
// show-ahead result FIFO.
// Optional feature: define PULSE_RX_TRUTH_EN to latch in_en[0] truth samples
// and carry the truth value associated with each peak through the FIFO.
//
// Handshake: a record sits at the FIFO head while rd_valid=1; it is consumed
// at the rising edge where rd_en=1 and rd_valid=1. rd_en while empty is a
// no-op. There is no back-pressure on the sample side: records arriving at a
// full FIFO (with no pop in the same cycle) are dropped and flagged in
// overflow.
module pulse_rx #(
    parameter int DW     = 23,
    parameter int THR    = 100,
    parameter int MAXLEN = 64,
    parameter int AW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           in_en,
    input  logic signed [DW-1:0] in_data,
    input  logic                 rd_en,
    input  logic                 clr_ovf,
    output logic                 rd_valid,
    output logic signed [DW-1:0] rd_peak,
    output logic [15:0]          rd_time,
    output logic [7:0]           rd_len,
    output logic                 rd_trunc,
    output logic [DW-1:0]        rd_truth,
    output logic                 full,
    output logic                 overflow,
    output logic [1:0]           dbg_state
);

    localparam int DEPTH = 1 << AW;
    localparam logic signed [DW-1:0] THR_V    = DW'(THR);
    localparam logic [7:0]           MAXLEN_V = 8'(MAXLEN);
    localparam logic [AW:0]          DEPTH_V  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        PUSH  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q;
    logic                  armed_q, armed_d;
    logic signed [DW-1:0]  peak_q, peak_d;
    logic [15:0]           time_q, time_d;
    logic [7:0]            len_q, len_d;
    logic                  trunc_q, trunc_d;
    logic                  take_truth;

    logic                  ro;
    logic                  hit;

    assign ro  = in_en[1];
    assign hit = (in_data >= THR_V);
    assign dbg_state = state_q;

    // Timestamp: counts readout samples, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    cnt_q <= '0;
        else if (ro) cnt_q <= cnt_q + 16'd1;
    end

    // Next-state and record-field update. PUSH handles a concurrent sample
    // exactly like IDLE so back-to-back pulses lose no sample.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        peak_d     = peak_q;
        time_d     = time_q;
        len_d      = len_q;
        trunc_d    = trunc_q;
        take_truth = 1'b0;
        case (state_q)
            PULSE: begin
                if (ro) begin
                    if (hit) begin
                        len_d = len_q + 8'd1;
                        if (in_data > peak_q) begin
                            peak_d     = in_data;
                            time_d     = cnt_q;
                            take_truth = 1'b1;
                        end
                        if (len_q + 8'd1 == MAXLEN_V) begin
                            // Truncated: must see a sub-threshold sample
                            // before another pulse may start.
                            state_d = PUSH;
                            trunc_d = 1'b1;
                            armed_d = 1'b0;
                        end
                    end else begin
                        state_d = PUSH;
                        trunc_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (ro) begin
                    if (hit && armed_q) begin
                        state_d    = PULSE;
                        peak_d     = in_data;
                        time_d     = cnt_q;
                        len_d      = 8'd1;
                        trunc_d    = 1'b0;
                        take_truth = 1'b1;
                    end else if (!hit) begin
                        armed_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // FSM state and current-pulse record registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            peak_q  <= '0;
            time_q  <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            peak_q  <= peak_d;
            time_q  <= time_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
        end
    end

`ifdef PULSE_RX_TRUTH_EN
    logic [DW-1:0] truth_last_q;
    logic [DW-1:0] truth_sel;
    logic [DW-1:0] truth_q;

    // A truth strobe in the same cycle as the peak wins over the old value.
    assign truth_sel = in_en[0] ? in_data : truth_last_q;

    // Latest truth sample, and the truth value bound to the current peak.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            truth_last_q <= '0;
            truth_q      <= '0;
        end else begin
            if (in_en[0])   truth_last_q <= in_data;
            if (take_truth) truth_q      <= truth_sel;
        end
    end
`else
    logic unused_truth;
    assign unused_truth = in_en[0] ^ take_truth;
`endif

    // ---------------- result FIFO ----------------
    logic signed [DW-1:0] mem_peak  [DEPTH];
    logic [15:0]          mem_time  [DEPTH];
    logic [7:0]           mem_len   [DEPTH];
    logic                 mem_trunc [DEPTH];
`ifdef PULSE_RX_TRUTH_EN
    logic [DW-1:0]        mem_truth [DEPTH];
`endif
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 push, pop, wr_ok;

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == DEPTH_V);
    assign push     = (state_q == PUSH);
    assign pop      = rd_en && rd_valid;
    assign wr_ok    = push && (!full || pop);

    assign rd_peak  = mem_peak[rd_ptr_q];
    assign rd_time  = mem_time[rd_ptr_q];
    assign rd_len   = mem_len[rd_ptr_q];
    assign rd_trunc = mem_trunc[rd_ptr_q];
`ifdef PULSE_RX_TRUTH_EN
    assign rd_truth = mem_truth[rd_ptr_q];
`else
    assign rd_truth = '0;
`endif

    // Storage; cleared on reset so an empty FIFO reads all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_peak[i]  <= '0;
                mem_time[i]  <= '0;
                mem_len[i]   <= '0;
                mem_trunc[i] <= 1'b0;
`ifdef PULSE_RX_TRUTH_EN
                mem_truth[i] <= '0;
`endif
            end
        end else if (wr_ok) begin
            mem_peak[wr_ptr_q]  <= peak_q;
            mem_time[wr_ptr_q]  <= time_q;
            mem_len[wr_ptr_q]   <= len_q;
            mem_trunc[wr_ptr_q] <= trunc_q;
`ifdef PULSE_RX_TRUTH_EN
            mem_truth[wr_ptr_q] <= truth_q;
`endif
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow: a dropped record beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        overflow <= 1'b0;
        else if (push && full && !pop)   overflow <= 1'b1;
        else if (clr_ovf)                overflow <= 1'b0;
    end

endmodule

// File: tb/tb_pulse_rx.sv
// tb_pulse_rx: scoreboard bench for pulse_rx (default parameters).
module tb_pulse_rx;

    localparam int DW    = 23;
    localparam int THR   = 100;
    localparam int REC_W = DW + 16 + 8 + 1 + DW;
`ifdef PULSE_RX_TRUTH_EN
    localparam bit TRUTH = 1'b1;
`else
    localparam bit TRUTH = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           in_en;
    logic signed [DW-1:0] in_data;
    logic                 rd_en;
    logic                 clr_ovf;
    logic                 rd_valid;
    logic signed [DW-1:0] rd_peak;
    logic [15:0]          rd_time;
    logic [7:0]           rd_len;
    logic                 rd_trunc;
    logic [DW-1:0]        rd_truth;
    logic                 full;
    logic                 overflow;
    logic [1:0]           dbg_state;

    logic [REC_W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;
    int tb_cnt = 0;

    pulse_rx #(.DW(DW), .THR(THR), .MAXLEN(64), .AW(3)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_valid(rd_valid),
        .rd_peak(rd_peak), .rd_time(rd_time), .rd_len(rd_len),
        .rd_trunc(rd_trunc), .rd_truth(rd_truth), .full(full),
        .overflow(overflow), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input int peak, input int t,
                                                input int len, input bit trunc,
                                                input int truth);
        logic [DW-1:0] tr;
        tr = TRUTH ? DW'(truth) : '0;
        return {DW'(peak), 16'(t), 8'(len), trunc, tr};
    endfunction

    // One sample strobe for one clock cycle.
    task automatic send(input logic [1:0] en, input int d);
        @(negedge clk);
        in_en   = en;
        in_data = DW'(d);
        @(posedge clk);
        #1;
        in_en = 2'b00;
        if (en[1]) tb_cnt++;
    endtask

    task automatic send_ro(input int d);
        send(2'b10, d);
    endtask

    // Compare the FIFO head against the scoreboard, then pop it.
    task automatic pop_check(input string tag);
        logic [REC_W-1:0] e;
        check_val({tag, "_valid"}, 128'(rd_valid), 128'(1));
        if (exp_q.size() == 0) begin
            check_val({tag, "_expq_empty"}, 128'(1), 128'(0));
        end else begin
            e = exp_q.pop_front();
            check_val(tag, 128'({rd_peak, rd_time, rd_len, rd_trunc, rd_truth}),
                      128'(e));
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        int len;
        int mx;
        int mx_t;
        int v;
        rst = 1'b0; in_en = 2'b00; in_data = '0; rd_en = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check_val("rst_valid", 128'(rd_valid), 128'(0));
        check_val("rst_full",  128'(full), 128'(0));
        check_val("rst_ovf",   128'(overflow), 128'(0));
        check_val("rst_state", 128'(dbg_state), 128'(0));
        check_val("rst_data",  128'({rd_peak, rd_time, rd_len, rd_trunc, rd_truth}), 128'(0));
        @(negedge clk);
        rst = 1'b1;

        // basic pulse, latency, and push+pop while empty
        send_ro(0); send_ro(150); send_ro(300); send_ro(200); send_ro(50);
        exp_q.push_back(mk_rec(300, 2, 3, 1'b0, 0));
        check_val("lat_0", 128'(rd_valid), 128'(0));
        check_val("lat_push_state", 128'(dbg_state), 128'(2));
        rd_en = 1'b1;
        wait_edge();
        rd_en = 1'b0;
        check_val("lat_1", 128'(rd_valid), 128'(1));
        pop_check("basic");
        check_val("basic_empty", 128'(rd_valid), 128'(0));

        // pop while empty is ignored
        rd_en = 1'b1;
        wait_edge();
        rd_en = 1'b0;
        check_val("empty_pop_valid", 128'(rd_valid), 128'(0));
        check_val("empty_pop_full",  128'(full), 128'(0));

        // truncation at MAXLEN, then re-arm
        start = tb_cnt;
        repeat (70) send_ro(500);
        exp_q.push_back(mk_rec(500, start, 64, 1'b1, 0));
        pop_check("trunc");
        check_val("trunc_no_second", 128'(rd_valid), 128'(0));
        send_ro(0);
        start = tb_cnt;
        send_ro(200); send_ro(0);
        exp_q.push_back(mk_rec(200, start, 1, 1'b0, 0));
        wait_edge();
        pop_check("rearm");

        // random pulses
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 10);
            start = tb_cnt;
            mx = -1;
            mx_t = 0;
            for (int i = 0; i < len; i++) begin
                v = $urandom_range(THR, 2000);
                if (v > mx) begin mx = v; mx_t = start + i; end
                send_ro(v);
            end
            send_ro($urandom_range(0, THR - 1));
            exp_q.push_back(mk_rec(mx, mx_t, len, 1'b0, 0));
            wait_edge();
            pop_check("rand");
        end

        // nine pulses, no reads -> overflow
        for (int i = 0; i < 9; i++) begin
            start = tb_cnt;
            send_ro(1000 + i); send_ro(0);
            if (i < 8) exp_q.push_back(mk_rec(1000 + i, start, 1, 1'b0, 0));
        end
        wait_edge();
        check_val("ovf_full", 128'(full), 128'(1));
        check_val("ovf_set",  128'(overflow), 128'(1));
        @(negedge clk);
        clr_ovf = 1'b1;
        wait_edge();
        clr_ovf = 1'b0;
        check_val("ovf_clr", 128'(overflow), 128'(0));
        for (int i = 0; i < 8; i++) pop_check("ovf_rec");
        check_val("ovf_drained", 128'(rd_valid), 128'(0));

        // full FIFO, pop during the ninth push
        for (int i = 0; i < 8; i++) begin
            start = tb_cnt;
            send_ro(1500 + i); send_ro(0);
            exp_q.push_back(mk_rec(1500 + i, start, 1, 1'b0, 0));
        end
        wait_edge();
        check_val("pp_full", 128'(full), 128'(1));
        start = tb_cnt;
        send_ro(1600); send_ro(0);
        pop_check("pp_head");
        exp_q.push_back(mk_rec(1600, start, 1, 1'b0, 0));
        check_val("pp_no_ovf", 128'(overflow), 128'(0));
        check_val("pp_full2",  128'(full), 128'(1));
        for (int i = 0; i < 8; i++) pop_check("pp_rec");
        check_val("pp_drained", 128'(rd_valid), 128'(0));

        // truth association
        send(2'b01, 77);
        start = tb_cnt;
        send_ro(120); send_ro(400); send_ro(0);
        exp_q.push_back(mk_rec(400, start + 1, 2, 1'b0, 77));
        wait_edge();
        pop_check("truth77");
        start = tb_cnt;
        send(2'b11, 300); send_ro(0);
        exp_q.push_back(mk_rec(300, start, 1, 1'b0, 300));
        wait_edge();
        pop_check("truth_both");

        // reset mid-pulse
        send_ro(150); send_ro(250);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) wait_edge();
        check_val("midrst_valid", 128'(rd_valid), 128'(0));
        check_val("midrst_state", 128'(dbg_state), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        tb_cnt = 0;
        send_ro(0); send_ro(200); send_ro(0);
        exp_q.push_back(mk_rec(200, 1, 1, 1'b0, 0));
        wait_edge();
        pop_check("midrst_rec");
        check_val("midrst_only", 128'(rd_valid), 128'(0));
        check_val("expq_left", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
